mmio_tilelink_responder: RTL and testbench

MMIO_TILELINK_RESPONDER -- requirements
Module: mmio_tilelink_responder

---
 rtl/mmio_tilelink_responder_pkg.sv | 32 +++
 rtl/mmio_tilelink_responder_if.sv | 62 ++++++
 rtl/mmio_tilelink_responder.sv | 176 +++++++++++++++++
 tb/tb_mmio_tilelink_responder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_tilelink_responder_pkg.sv
// Shared widths, TileLink type codes and FSM states
// for the MMIO TileLink responder.
package mmio_tilelink_responder_pkg;

    localparam int ADDR_BLOCK_W = 26;
    localparam int BEAT_W       = 3;
    localparam int XACT_W       = 2;
    localparam int DATA_W       = 64;
    localparam int UNION_W      = 12;
    localparam int A_TYPE_W     = 3;
    localparam int G_TYPE_W     = 4;
    localparam int MASK_W       = DATA_W / 8;
    localparam int MEM_ADDR_W   = ADDR_BLOCK_W + BEAT_W;

    localparam logic [A_TYPE_W-1:0] A_GET     = 3'd0;
    localparam logic [A_TYPE_W-1:0] A_GET_BLK = 3'd1;
    localparam logic [A_TYPE_W-1:0] A_PUT     = 3'd2;
    localparam logic [A_TYPE_W-1:0] A_PUT_BLK = 3'd3;

    localparam logic [G_TYPE_W-1:0] G_PUT_ACK  = 4'd3;
    localparam logic [G_TYPE_W-1:0] G_GET_BEAT = 4'd4;
    localparam logic [G_TYPE_W-1:0] G_GET_BLK  = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUTBLK,
        S_RD_REQ,
        S_RD_WAIT,
        S_GNT
    } state_e;

endpackage

// File: rtl/mmio_tilelink_responder_if.sv
// Acquire / Grant / backend memory bundle of the responder.
// slave is the responder's view, master the client+backend view.
interface mmio_tilelink_responder_if;
    import mmio_tilelink_responder_pkg::*;

    logic                    acq_ready;
    logic                    acq_valid;
    logic [ADDR_BLOCK_W-1:0] acq_addr_block;
    logic [XACT_W-1:0]       acq_client_xact_id;
    logic [BEAT_W-1:0]       acq_addr_beat;
    logic                    acq_is_builtin_type;
    logic [A_TYPE_W-1:0]     acq_a_type;
    logic [UNION_W-1:0]      acq_union;
    logic [DATA_W-1:0]       acq_data;

    logic                    gnt_ready;
    logic                    gnt_valid;
    logic [BEAT_W-1:0]       gnt_addr_beat;
    logic [XACT_W-1:0]       gnt_client_xact_id;
    logic                    gnt_manager_xact_id;
    logic                    gnt_is_builtin_type;
    logic [G_TYPE_W-1:0]     gnt_g_type;
    logic [DATA_W-1:0]       gnt_data;

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic                    mem_req_write;
    logic [MEM_ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]       mem_req_wdata;
    logic [MASK_W-1:0]       mem_req_wmask;
    logic                    mem_resp_valid;
    logic [DATA_W-1:0]       mem_resp_rdata;

    modport slave (
        output acq_ready,
        input  acq_valid, acq_addr_block, acq_client_xact_id,
        input  acq_addr_beat, acq_is_builtin_type, acq_a_type,
        input  acq_union, acq_data,
        input  gnt_ready,
        output gnt_valid, gnt_addr_beat, gnt_client_xact_id,
        output gnt_manager_xact_id, gnt_is_builtin_type,
        output gnt_g_type, gnt_data,
        output mem_req_valid, mem_req_write, mem_req_addr,
        output mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport master (
        input  acq_ready,
        output acq_valid, acq_addr_block, acq_client_xact_id,
        output acq_addr_beat, acq_is_builtin_type, acq_a_type,
        output acq_union, acq_data,
        output gnt_ready,
        input  gnt_valid, gnt_addr_beat, gnt_client_xact_id,
        input  gnt_manager_xact_id, gnt_is_builtin_type,
        input  gnt_g_type, gnt_data,
        input  mem_req_valid, mem_req_write, mem_req_addr,
        input  mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/mmio_tilelink_responder.sv
// TileLink Acquire/Grant responder bridging one outstanding
// transaction at a time onto a simple request/response memory port.
module mmio_tilelink_responder
    import mmio_tilelink_responder_pkg::*;
#(
    parameter int BEATS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    mmio_tilelink_responder_if.slave bus,
    output logic                     err_unsupported
);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [XACT_W-1:0]       tag_q, tag_d;
    logic [ADDR_BLOCK_W-1:0] addr_q, addr_d;
    logic                    blk_q, blk_d;
    logic [G_TYPE_W-1:0]     gtype_q, gtype_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    err_q, err_d;

    logic is_get, is_get_blk, is_put, is_put_blk;
    logic beat_match, acq_fire_wr;
    logic unused_union;

    assign is_get     = bus.acq_is_builtin_type && (bus.acq_a_type == A_GET);
    assign is_get_blk = bus.acq_is_builtin_type && (bus.acq_a_type == A_GET_BLK);
    assign is_put     = bus.acq_is_builtin_type && (bus.acq_a_type == A_PUT);
    assign is_put_blk = bus.acq_is_builtin_type && (bus.acq_a_type == A_PUT_BLK);
    assign beat_match = is_put_blk && (bus.acq_addr_beat == beat_q);
    assign acq_fire_wr = bus.acq_valid && bus.mem_req_ready;

    assign unused_union = ^{bus.acq_union[UNION_W-1:9], bus.acq_union[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            tag_q   <= '0;
            addr_q  <= '0;
            blk_q   <= 1'b0;
            gtype_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
            blk_q   <= blk_d;
            gtype_q <= gtype_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        blk_d   = blk_q;
        gtype_d = gtype_q;
        data_d  = data_q;
        err_d   = err_q;

        bus.acq_ready     = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_write = 1'b0;
        bus.mem_req_addr  = {addr_q, beat_q};
        bus.mem_req_wdata = '0;
        bus.mem_req_wmask = '0;

        unique case (state_q)
            S_IDLE: begin
                if (is_put || is_put_blk) begin
                    // Single-beat writes pass straight through to the backend
                    bus.acq_ready     = bus.mem_req_ready;
                    bus.mem_req_valid = bus.acq_valid;
                    bus.mem_req_write = 1'b1;
                    bus.mem_req_addr  = {bus.acq_addr_block, bus.acq_addr_beat};
                    bus.mem_req_wdata = bus.acq_data;
                    bus.mem_req_wmask = is_put_blk ? '1 : bus.acq_union[8:1];
                    if (acq_fire_wr) begin
                        tag_d   = bus.acq_client_xact_id;
                        addr_d  = bus.acq_addr_block;
                        blk_d   = 1'b0;
                        gtype_d = G_PUT_ACK;
                        if (is_put || BEAT_LAST == '0) begin
                            state_d = S_GNT;
                            beat_d  = '0;
                        end else begin
                            state_d = S_PUTBLK;
                            beat_d  = beat_q + BEAT_ONE;
                        end
                    end
                end else begin
                    bus.acq_ready = 1'b1;
                    if (bus.acq_valid) begin
                        tag_d  = bus.acq_client_xact_id;
                        addr_d = bus.acq_addr_block;
                        if (is_get || is_get_blk) begin
                            blk_d   = is_get_blk;
                            beat_d  = is_get_blk ? '0 : bus.acq_addr_beat;
                            gtype_d = is_get_blk ? G_GET_BLK : G_GET_BEAT;
                            state_d = S_RD_REQ;
                        end else begin
                            err_d   = 1'b1;
                            blk_d   = 1'b0;
                            beat_d  = '0;
                            gtype_d = G_PUT_ACK;
                            state_d = S_GNT;
                        end
                    end
                end
            end
            S_PUTBLK: begin
                if (beat_match) begin
                    bus.acq_ready     = bus.mem_req_ready;
                    bus.mem_req_valid = bus.acq_valid;
                    bus.mem_req_write = 1'b1;
                    bus.mem_req_wdata = bus.acq_data;
                    bus.mem_req_wmask = '1;
                    if (acq_fire_wr) begin
                        if (beat_q == BEAT_LAST) begin
                            state_d = S_GNT;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + BEAT_ONE;
                        end
                    end
                end else begin
                    // Stray beats are swallowed so the client cannot wedge
                    bus.acq_ready = 1'b1;
                    if (bus.acq_valid) err_d = 1'b1;
                end
            end
            S_RD_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (bus.mem_resp_valid) begin
                    data_d  = bus.mem_resp_rdata;
                    state_d = S_GNT;
                end
            end
            S_GNT: begin
                if (bus.gnt_ready) begin
                    if (blk_q && beat_q != BEAT_LAST) begin
                        beat_d  = beat_q + BEAT_ONE;
                        state_d = S_RD_REQ;
                    end else begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.gnt_valid           = (state_q == S_GNT);
    assign bus.gnt_addr_beat       = (gtype_q == G_PUT_ACK) ? '0 : beat_q;
    assign bus.gnt_client_xact_id  = tag_q;
    assign bus.gnt_manager_xact_id = 1'b0;
    assign bus.gnt_is_builtin_type = 1'b1;
    assign bus.gnt_g_type          = gtype_q;
    assign bus.gnt_data            = data_q;
    assign err_unsupported         = err_q;

endmodule

// File: tb/tb_mmio_tilelink_responder.sv
// Scoreboard bench for the MMIO TileLink responder: directed Acquires,
// queued expected memory requests and Grants, popped by monitors.
`timescale 1ns/1ps
module tb_mmio_tilelink_responder;
    import mmio_tilelink_responder_pkg::*;

    typedef struct {
        bit          wr;
        logic [28:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } mexp_t;

    typedef struct {
        logic [2:0]  beat;
        logic [1:0]  tag;
        logic [3:0]  gt;
        logic [63:0] data;
        bit          chk_data;
    } gexp_t;

    logic clk = 1'b0;
    logic reset;
    logic err;

    mmio_tilelink_responder_if bus();

    mmio_tilelink_responder #(.BEATS(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .err_unsupported (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    mexp_t mq[$];
    gexp_t gq[$];

    bit          rdy_toggle = 1'b0;
    bit          stray      = 1'b0;
    bit          drop_en    = 1'b0;
    logic [2:0]  drop_beat  = 3'd0;
    logic [63:0] rd_base    = 64'h0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic void flag(string nm);
        n_chk++;
        $display("FAIL %s at %0t", nm, $time);
    endfunction

    function automatic void exp_mem(bit wr, logic [25:0] blk, logic [2:0] beat,
                                    logic [63:0] d, logic [7:0] m);
        mexp_t e;
        e.wr    = wr;
        e.addr  = {blk, beat};
        e.wdata = d;
        e.mask  = m;
        mq.push_back(e);
    endfunction

    function automatic void exp_gnt(logic [2:0] beat, logic [1:0] tag, logic [3:0] gt,
                                    logic [63:0] d, bit cd);
        gexp_t e;
        e.beat     = beat;
        e.tag      = tag;
        e.gt       = gt;
        e.data     = d;
        e.chk_data = cd;
        gq.push_back(e);
    endfunction

    // Backend: ready pattern, same-cycle read data, optional stray/dropped responses
    initial begin : backend
        logic       fire;
        logic [2:0] b;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            fire = reset && bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_write;
            b    = bus.mem_req_addr[2:0];
            if (drop_en && b == drop_beat) fire = 1'b0;
            @(posedge clk);
            #1;
            bus.mem_resp_valid = fire || stray;
            bus.mem_resp_rdata = fire ? (rd_base | (64'(b) * 64'h11)) : 64'hBAD0_BAD0;
            bus.mem_req_ready  = rdy_toggle ? ~bus.mem_req_ready : 1'b1;
        end
    end

    initial begin : mem_mon
        mexp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.mem_req_valid && bus.mem_req_ready) begin
                if (mq.size() == 0) flag("mem_unexpected");
                else begin
                    e = mq.pop_front();
                    chk("mem_write", 64'(bus.mem_req_write), 64'(e.wr));
                    chk("mem_addr", 64'(bus.mem_req_addr), 64'(e.addr));
                    if (e.wr) begin
                        chk("mem_wdata", bus.mem_req_wdata, e.wdata);
                        chk("mem_wmask", 64'(bus.mem_req_wmask), 64'(e.mask));
                    end
                end
            end
        end
    end

    initial begin : gnt_mon
        gexp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.gnt_valid && bus.gnt_ready) begin
                if (gq.size() == 0) flag("gnt_unexpected");
                else begin
                    e = gq.pop_front();
                    chk("gnt_beat", 64'(bus.gnt_addr_beat), 64'(e.beat));
                    chk("gnt_tag", 64'(bus.gnt_client_xact_id), 64'(e.tag));
                    chk("gnt_gtype", 64'(bus.gnt_g_type), 64'(e.gt));
                    chk("gnt_mgr_id", 64'(bus.gnt_manager_xact_id), 64'h0);
                    chk("gnt_builtin", 64'(bus.gnt_is_builtin_type), 64'h1);
                    if (e.chk_data) chk("gnt_data", bus.gnt_data, e.data);
                end
            end
        end
    end

    task automatic send_acq(input bit bi, input logic [2:0] at, input logic [25:0] blk,
                            input logic [2:0] beat, input logic [1:0] tag,
                            input logic [7:0] mask, input logic [63:0] data);
        int n;
        n = 0;
        bus.acq_is_builtin_type = bi;
        bus.acq_a_type          = at;
        bus.acq_addr_block      = blk;
        bus.acq_addr_beat       = beat;
        bus.acq_client_xact_id  = tag;
        bus.acq_union           = {3'b000, mask, 1'b0};
        bus.acq_data            = data;
        bus.acq_valid           = 1'b1;
        @(negedge clk);
        while (!bus.acq_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.acq_ready) flag("acq_timeout");
        @(posedge clk);
        #1;
        bus.acq_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((mq.size() != 0 || gq.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_drained"}, 64'(mq.size() + gq.size()), 64'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        reset                   = 1'b0;
        bus.acq_valid           = 1'b0;
        bus.acq_addr_block      = '0;
        bus.acq_client_xact_id  = '0;
        bus.acq_addr_beat       = '0;
        bus.acq_is_builtin_type = 1'b1;
        bus.acq_a_type          = '0;
        bus.acq_union           = '0;
        bus.acq_data            = '0;
        bus.gnt_ready           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt_valid", 64'(bus.gnt_valid), 64'h0);
        chk("rst_mem_valid", 64'(bus.mem_req_valid), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_gnt_tag", 64'(bus.gnt_client_xact_id), 64'h0);
        chk("rst_gnt_data", bus.gnt_data, 64'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Put: one write at 0x82, one PutAck a cycle after the fire
        exp_mem(1'b1, 26'h10, 3'd2, 64'hA5A5, 8'h0F);
        exp_gnt(3'd0, 2'd1, G_PUT_ACK, 64'h0, 1'b0);
        send_acq(1'b1, A_PUT, 26'h10, 3'd2, 2'd1, 8'h0F, 64'hA5A5);
        chk("put_latency", 64'(bus.gnt_valid), 64'h1);
        drain("put");

        // Get with same-cycle backend: Grant in the third cycle after the fire
        rd_base = 64'h1234_0000;
        exp_mem(1'b0, 26'h2A, 3'd6, 64'h0, 8'h0);
        exp_gnt(3'd6, 2'd0, G_GET_BEAT, 64'h1234_0066, 1'b1);
        send_acq(1'b1, A_GET, 26'h2A, 3'd6, 2'd0, 8'h0, 64'h0);
        chk("get_lat_c1", 64'(bus.gnt_valid), 64'h0);
        @(posedge clk);
        #1;
        chk("get_lat_c2", 64'(bus.gnt_valid), 64'h0);
        @(posedge clk);
        #1;
        chk("get_lat_c3", 64'(bus.gnt_valid), 64'h1);
        drain("get");

        // GetBlock starts at beat 0 whatever addr_beat says
        rd_base = 64'h0;
        for (int b = 0; b < 8; b++) begin
            exp_mem(1'b0, 26'h3, 3'(b), 64'h0, 8'h0);
            exp_gnt(3'(b), 2'd2, G_GET_BLK, 64'(b) * 64'h11, 1'b1);
        end
        send_acq(1'b1, A_GET_BLK, 26'h3, 3'd5, 2'd2, 8'h0, 64'h0);
        drain("getblk");

        // PutBlock under toggling backend ready, full mask forced
        rdy_toggle = 1'b1;
        for (int b = 0; b < 8; b++)
            exp_mem(1'b1, 26'h1C0, 3'(b), 64'hC0DE_0000 + 64'(b), 8'hFF);
        for (int b = 0; b < 8; b++) begin
            if (b == 7) exp_gnt(3'd0, 2'd3, G_PUT_ACK, 64'h0, 1'b0);
            send_acq(1'b1, A_PUT_BLK, 26'h1C0, 3'(b), 2'd3, 8'h3C, 64'hC0DE_0000 + 64'(b));
        end
        drain("putblk");
        rdy_toggle = 1'b0;

        // Grant held off: fields stable, no Acquire accepted
        rd_base = 64'hDEAD_0000;
        exp_mem(1'b0, 26'h55, 3'd6, 64'h0, 8'h0);
        exp_gnt(3'd6, 2'd3, G_GET_BEAT, 64'hDEAD_0066, 1'b1);
        bus.gnt_ready = 1'b0;
        send_acq(1'b1, A_GET, 26'h55, 3'd6, 2'd3, 8'h0, 64'h0);
        n = 0;
        while (!bus.gnt_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_gnt_valid", 64'(bus.gnt_valid), 64'h1);
            chk("stall_gnt_data", bus.gnt_data, 64'hDEAD_0066);
            chk("stall_acq_ready", 64'(bus.acq_ready), 64'h0);
            @(posedge clk);
            #1;
        end
        bus.gnt_ready = 1'b1;
        drain("stall");

        // Read data outside RD_WAIT is ignored
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_no_gnt", 64'(bus.gnt_valid), 64'h0);

        // Unsupported Acquires: PutAck, no memory access, sticky error
        chk("err_before", 64'(err), 64'h0);
        exp_gnt(3'd0, 2'd2, G_PUT_ACK, 64'h0, 1'b0);
        send_acq(1'b1, 3'd4, 26'h77, 3'd1, 2'd2, 8'hFF, 64'h1);
        drain("unsup_type");
        chk("err_set", 64'(err), 64'h1);
        exp_gnt(3'd0, 2'd1, G_PUT_ACK, 64'h0, 1'b0);
        send_acq(1'b0, A_PUT, 26'h77, 3'd1, 2'd1, 8'hFF, 64'h2);
        drain("unsup_custom");
        chk("err_sticky", 64'(err), 64'h1);

        // PutBlock interrupted by mismatched beats that must not be written
        exp_mem(1'b1, 26'h9, 3'd0, 64'h90, 8'hFF);
        send_acq(1'b1, A_PUT_BLK, 26'h9, 3'd0, 2'd0, 8'hFF, 64'h90);
        send_acq(1'b1, A_PUT_BLK, 26'h9, 3'd3, 2'd0, 8'hFF, 64'hBAD);
        send_acq(1'b1, A_GET, 26'h9, 3'd1, 2'd0, 8'h0, 64'h0);
        for (int b = 1; b < 8; b++) begin
            exp_mem(1'b1, 26'h9, 3'(b), 64'h90 + 64'(b), 8'hFF);
            if (b == 7) exp_gnt(3'd0, 2'd0, G_PUT_ACK, 64'h0, 1'b0);
            send_acq(1'b1, A_PUT_BLK, 26'h9, 3'(b), 2'd0, 8'hFF, 64'h90 + 64'(b));
        end
        drain("putblk_bad");

        // Reset while GetBlock beat 3 waits for data
        rd_base   = 64'h0;
        drop_beat = 3'd3;
        drop_en   = 1'b1;
        for (int b = 0; b < 4; b++) exp_mem(1'b0, 26'h7, 3'(b), 64'h0, 8'h0);
        for (int b = 0; b < 3; b++) exp_gnt(3'(b), 2'd1, G_GET_BLK, 64'(b) * 64'h11, 1'b1);
        send_acq(1'b1, A_GET_BLK, 26'h7, 3'd0, 2'd1, 8'h0, 64'h0);
        n = 0;
        while ((mq.size() != 0 || gq.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("rd_wait_reached", 64'(mq.size() + gq.size()), 64'h0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_gnt_valid", 64'(bus.gnt_valid), 64'h0);
        chk("midrst_mem_valid", 64'(bus.mem_req_valid), 64'h0);
        chk("midrst_err", 64'(err), 64'h0);
        chk("midrst_gnt_tag", 64'(bus.gnt_client_xact_id), 64'h0);
        chk("midrst_gnt_data", bus.gnt_data, 64'h0);
        chk("midrst_gtype", 64'(bus.gnt_g_type), 64'h0);
        drop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        rd_base = 64'h5000;
        exp_mem(1'b0, 26'h21, 3'd4, 64'h0, 8'h0);
        exp_gnt(3'd4, 2'd2, G_GET_BEAT, 64'h5044, 1'b1);
        send_acq(1'b1, A_GET, 26'h21, 3'd4, 2'd2, 8'h0, 64'h0);
        drain("post_reset_get");
        chk("post_reset_err", 64'(err), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
